// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: one-hot instruction-type encodings,
// register-usage masks, hazard FSM states and the EX-stage tracker record.
package riscv_pkg;

  localparam logic [5:0] TYPE_R = 6'b100000;
  localparam logic [5:0] TYPE_I = 6'b010000;
  localparam logic [5:0] TYPE_S = 6'b001000;
  localparam logic [5:0] TYPE_B = 6'b000100;
  localparam logic [5:0] TYPE_J = 6'b000010;
  localparam logic [5:0] TYPE_U = 6'b000001;

  // Which instruction types read rs1/rs2 or write rd
  localparam logic [5:0] RS1_USERS  = TYPE_R | TYPE_I | TYPE_S | TYPE_B;
  localparam logic [5:0] RS2_USERS  = TYPE_R | TYPE_S | TYPE_B;
  localparam logic [5:0] RD_WRITERS = TYPE_R | TYPE_I | TYPE_J | TYPE_U;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       writes;
    logic       load;
  } ex_track_t;

  function automatic logic is_onehot6(input logic [5:0] t);
    return (t != 6'b000000) && ((t & (t - 6'd1)) == 6'b000000);
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// ID/EX-side hazard bus: the pipeline (master) presents the decoded ID
// instruction and branch resolution; the controller (slave) returns enables.
interface hazard_controller_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [5:0]       id_type;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       id_rd;
  logic             id_is_load;
  logic             ex_branch_taken;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             alusrc;
  logic             stall_active;
  logic             illegal_type;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_type, id_rs1, id_rs2, id_rd, id_is_load, ex_branch_taken,
    input  pc_en, ifid_en, ifid_flush, idex_flush, alusrc, stall_active,
           illegal_type, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_type, id_rs1, id_rs2, id_rd, id_is_load, ex_branch_taken,
    output pc_en, ifid_en, ifid_flush, idex_flush, alusrc, stall_active,
           illegal_type, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_detect.sv
// Combinational register-usage decode of the ID instruction and load-use
// comparison against the instruction currently held in EX.
module hazard_detect
  import riscv_pkg::*;
(
  input  logic       id_valid,
  input  logic [5:0] id_type,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  ex_track_t  ex,
  output logic       illegal,
  output logic       uses_rd,
  output logic       is_itype,
  output logic       load_use
);

  logic onehot_s;
  logic uses_rs1_s;
  logic uses_rs2_s;
  logic hit_s;

  // Decode source/destination usage and compare against the EX load
  always_comb begin
    onehot_s   = is_onehot6(id_type);
    uses_rs1_s = 1'b0;
    uses_rs2_s = 1'b0;
    uses_rd    = 1'b0;
    is_itype   = 1'b0;
    load_use   = 1'b0;
    if (onehot_s) begin
      uses_rs1_s = |(id_type & RS1_USERS);
      uses_rs2_s = |(id_type & RS2_USERS);
      uses_rd    = |(id_type & RD_WRITERS);
      is_itype   = (id_type == TYPE_I);
    end else begin
      uses_rs1_s = 1'b0;
      uses_rs2_s = 1'b0;
      uses_rd    = 1'b0;
      is_itype   = 1'b0;
    end
    illegal = id_valid & ~onehot_s;
    hit_s   = (uses_rs1_s && (id_rs1 == ex.rd)) || (uses_rs2_s && (id_rs2 == ex.rd));
    // x0 is hard-wired, so a load into it can never create a dependency
    if (id_valid && ex.valid && ex.load && ex.writes && (ex.rd != 5'd0)) begin
      load_use = hit_s;
    end else begin
      load_use = 1'b0;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stall, taken-branch redirect flush,
// EX-stage tracking, registered ALU source select and saturating event counters.
module hazard_controller
  import riscv_pkg::*;
#(
  parameter int FLUSH_LEN = 1,
  parameter int CNT_W     = 16
) (
  input  logic clock,
  input  logic reset,
  hazard_controller_if.slave hz
);

  localparam logic [2:0]       FLUSH_RELOAD = 3'(FLUSH_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

  hz_state_e        state_r;
  logic [2:0]       fcnt_r;
  ex_track_t        ex_r;
  logic             alusrc_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  logic pc_en_s;
  logic ifid_en_s;
  logic ifid_flush_s;
  logic idex_flush_s;
  logic capture_s;
  logic illegal_s;
  logic uses_rd_s;
  logic is_itype_s;
  logic load_use_s;

  hazard_detect u_detect (
    .id_valid (hz.id_valid),
    .id_type  (hz.id_type),
    .id_rs1   (hz.id_rs1),
    .id_rs2   (hz.id_rs2),
    .ex       (ex_r),
    .illegal  (illegal_s),
    .uses_rd  (uses_rd_s),
    .is_itype (is_itype_s),
    .load_use (load_use_s)
  );

  // Pipeline enables/flushes from current state and ID/EX conditions
  always_comb begin
    pc_en_s      = 1'b1;
    ifid_en_s    = 1'b1;
    ifid_flush_s = 1'b0;
    idex_flush_s = 1'b0;
    if (reset) begin
      pc_en_s      = 1'b0;
      ifid_en_s    = 1'b0;
      ifid_flush_s = 1'b1;
      idex_flush_s = 1'b1;
    end else begin
      case (state_r)
        ST_FLUSH: begin
          ifid_flush_s = 1'b1;
          idex_flush_s = 1'b1;
        end
        ST_RUN, ST_STALL: begin
          if (hz.ex_branch_taken) begin
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
          end else if (load_use_s) begin
            pc_en_s      = 1'b0;
            ifid_en_s    = 1'b0;
            idex_flush_s = 1'b1;
          end else begin
            pc_en_s      = 1'b1;
            ifid_en_s    = 1'b1;
          end
        end
        default: begin
          pc_en_s      = 1'b0;
          ifid_en_s    = 1'b0;
          ifid_flush_s = 1'b1;
          idex_flush_s = 1'b1;
        end
      endcase
    end
    capture_s = ~idex_flush_s & hz.id_valid & ~illegal_s;
  end

  // Hazard FSM with redirect-penalty countdown and saturating event counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_RUN;
      fcnt_r      <= 3'd0;
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_RUN, ST_STALL: begin
          if (hz.ex_branch_taken) begin
            state_r <= ST_FLUSH;
            fcnt_r  <= FLUSH_RELOAD;
            if (flush_cnt_r != CNT_MAX) begin
              flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end
          end else if (load_use_s) begin
            state_r <= ST_STALL;
            if ((state_r != ST_STALL) && (stall_cnt_r != CNT_MAX)) begin
              stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (fcnt_r == 3'd0) begin
            state_r <= ST_RUN;
          end else begin
            fcnt_r <= fcnt_r - 3'd1;
          end
        end
        default: begin
          state_r <= ST_RUN;
          fcnt_r  <= 3'd0;
        end
      endcase
    end
  end

  // EX tracker and ALU B-source select follow whatever enters ID/EX
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_r     <= '{valid: 1'b0, rd: 5'd0, writes: 1'b0, load: 1'b0};
      alusrc_r <= 1'b0;
    end else if (capture_s) begin
      ex_r     <= '{valid: 1'b1, rd: hz.id_rd, writes: uses_rd_s, load: hz.id_is_load};
      alusrc_r <= is_itype_s;
    end else begin
      ex_r     <= '{valid: 1'b0, rd: 5'd0, writes: 1'b0, load: 1'b0};
      alusrc_r <= 1'b0;
    end
  end

  assign hz.pc_en        = pc_en_s;
  assign hz.ifid_en      = ifid_en_s;
  assign hz.ifid_flush   = ifid_flush_s;
  assign hz.idex_flush   = idex_flush_s;
  assign hz.illegal_type = illegal_s & ~reset;
  assign hz.alusrc       = alusrc_r;
  assign hz.stall_active = (state_r == ST_STALL);
  assign hz.stall_cnt    = stall_cnt_r;
  assign hz.flush_cnt    = flush_cnt_r;

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter FLUSH_LEN, default 1, number of redirect-penalty cycles spent in FLUSH after a taken branch (legal 1..7).
REQ-002 SHALL have parameter CNT_W, default 16, width of the stall and flush event counters.
REQ-003 SHALL have ports:
  clock  input  1  sole clock, rising edge.
  reset  input  1  asynchronous, active-high.
  id_valid  input  1  ID stage holds a real instruction.
  id_type  input  6  one-hot type: bit5 R, bit4 I, bit3 S, bit2 B, bit1 J, bit0 U.
  id_rs1, id_rs2, id_rd  input  5 each  ID register indices.
  id_is_load  input  1  ID instruction is a load (I-type).
  ex_branch_taken  input  1  EX resolved a taken branch/jump this cycle.
  pc_en  output  1  PC may advance.
  ifid_en  output  1  IF/ID register may load.
  ifid_flush  output  1  IF/ID becomes bubble.
  idex_flush  output  1  ID/EX becomes bubble.
  alusrc  output  1  registered EX-stage ALU B-source select (1 = immediate).
  stall_active  output  1  FSM in STALL.
  illegal_type  output  1  ID id_type not one-hot while id_valid.
  stall_cnt, flush_cnt  output  CNT_W each  event counters.

Function
REQ-004 SHALL decode reads: rs1 used by R,I,S,B; rs2 used by R,S,B; rd written by R,I,J,U; index 0 never hazards.
REQ-005 SHALL treat a non-one-hot id_type with id_valid=1 as no reads/writes, assert illegal_type combinationally, and issue a bubble.
REQ-006 SHALL keep an EX tracker (ex_valid, ex_rd, ex_writes, ex_load) loaded every cycle from ID, or as bubble when idex_flush=1 or id_valid=0.
REQ-007 SHALL flag load_use when ex_valid & ex_load & ex_writes & ex_rd!=0 & ex_rd equals a used ID source, and id_valid=1.
REQ-008 SHALL implement FSM states RUN, STALL, FLUSH.
REQ-009 RUN/STALL, ex_branch_taken=1: ifid_flush=1, idex_flush=1, pc_en=1, ifid_en=1; next FLUSH, flush counter loaded FLUSH_LEN-1.
REQ-010 RUN/STALL, load_use and no branch: pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0; next STALL.
REQ-011 RUN/STALL, neither: pc_en=1, ifid_en=1, flushes 0; next RUN.
REQ-012 Branch SHALL take priority over load_use in the same cycle.
REQ-013 FLUSH: ifid_flush=1, idex_flush=1, pc_en=1, ifid_en=1; ex_branch_taken ignored; leave to RUN when counter is 0, else decrement.
REQ-014 alusrc SHALL be registered: next value 1 iff ID instruction is captured (not bubbled) and id_type==I; bubble gives 0.
REQ-015 stall_cnt SHALL increment on each entry into STALL; flush_cnt on each entry into FLUSH; both saturate at all-ones.
REQ-016 stall_active SHALL be 1 exactly while state==STALL.

Reset
REQ-017 While reset=1: state RUN, EX tracker bubble, alusrc 0, counters 0, stall_active 0.
REQ-018 While reset=1, combinational outputs SHALL be forced pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, illegal_type=0.
REQ-019 Reset asserted mid-FLUSH or mid-STALL SHALL abort immediately; first post-reset cycle is RUN.

Structure
REQ-020 Shared package riscv_pkg SHALL hold the one-hot instruction-type constants and the FSM state enum.
REQ-021 Source/destination usage decode and comparison SHALL be a combinational sub-module hazard_detect.

Verification
REQ-022 Load x5 then ADD x6,x5,x1 back-to-back -> one cycle pc_en=0, ifid_en=0, idex_flush=1, stall_cnt=1, alusrc 0 next cycle.
REQ-023 Load x0 then ADD using x0 -> no stall, stall_cnt stays 0.
REQ-024 ex_branch_taken=1 with FLUSH_LEN=1 -> flushes for 2 cycles total, flush_cnt=1, then RUN.
REQ-025 Branch taken and load_use same cycle -> flush path only, stall_cnt unchanged, state FLUSH.
REQ-026 Reset asserted during FLUSH -> outputs forced to reset values immediately; after release, ADDI x1,x0,3 gives alusrc=1 one cycle later.
REQ-027 id_type=6'b110000, id_valid=1 -> illegal_type=1, EX tracker bubble, alusrc 0.
